// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Purpose  : Shared types and helpers for the gated frequency counter.
//            Holds the FSM state encoding and a ceil-log2 helper that is used
//            to size the gate counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1
  } state_e;

  // Ceiling log2, never less than 1 so that derived vectors stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage : freq_meter_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Brings an asynchronous input into the clk domain through a
//            two-flop synchroniser and flags its rising edges.
// Ports    : clk     - system clock, rising edge
//            clr_n   - asynchronous active-low reset
//            d_async - input asynchronous to clk
//            rise    - one-cycle pulse per synchronised rising edge
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det (
  input  logic clk,
  input  logic clr_n,
  input  logic d_async,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // s1/s2 form the metastability filter; s3 only delays s2 for edge detect.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Gated frequency counter. Counts rising edges of an asynchronous
//            signal over a window of GATE_CYCLES clocks and publishes the
//            count with a one-cycle valid strobe at the end of each window.
// Ports    : clk      - system clock, rising edge
//            clr_n    - asynchronous active-low reset
//            en       - measurement enable, level-sensitive
//            sig_in   - signal under measurement, asynchronous to clk
//            freq     - rising-edge count of the last completed window
//            valid    - one-cycle strobe, freq/overflow updated this cycle
//            overflow - last completed window saturated the counter
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned       GATE_W    = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_e             state_q;
  logic [GATE_W-1:0]  gate_cnt_q;
  logic [CNT_W-1:0]   edge_cnt_q;
  logic               sat_q;
  logic [CNT_W-1:0]   freq_q;
  logic               valid_q;
  logic               overflow_q;

  logic               rise;
  logic [CNT_W-1:0]   edge_cnt_d;
  logic               sat_d;

  sync_edge_det u_sync (
    .clk     (clk),
    .clr_n   (clr_n),
    .d_async (sig_in),
    .rise    (rise)
  );

  // Saturating count including this cycle's rise. At window end this is
  // exactly what gets published, so a rise in the final cycle is counted.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (rise) begin
      if (&edge_cnt_q) begin
        sat_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
          if (en) begin
            state_q <= ST_GATE;
          end
        end

        ST_GATE: begin
          if (gate_cnt_q == GATE_LAST) begin
            // Window end wins over en=0: the completed window is published
            // and the next one starts immediately if still enabled.
            freq_q     <= edge_cnt_d;
            overflow_q <= sat_d;
            valid_q    <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            if (!en) begin
              state_q <= ST_IDLE;
            end
          end else if (!en) begin
            // Abort: partial window is discarded, published values held.
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            gate_cnt_q <= gate_cnt_q + 1'b1;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule : freq_meter
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Self-checking bench for freq_meter. Two instances (CNT_W=8 and
//            CNT_W=3) share stimulus; a window-level reference model counts
//            rise events per window and saturates the total afterwards.
// Ports    : none (testbench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int G = 16;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en;
  logic       sig_in;
  logic [7:0] freq8;
  logic       valid8;
  logic       ovf8;
  logic [2:0] freq3;
  logic       valid3;
  logic       ovf3;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .sig_in   (sig_in),
    .freq     (freq8),
    .valid    (valid8),
    .overflow (ovf8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) dut3 (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .sig_in   (sig_in),
    .freq     (freq3),
    .valid    (valid3),
    .overflow (ovf3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A sig_in rise sampled at edge k is seen by the counter at edge k+2;
  // hist1..hist3 hold the samples from the previous three edges.
  bit m_active;
  int m_pos;
  int m_cnt;
  bit hist1, hist2, hist3;
  int e_valid, e_freq8, e_ovf8, e_freq3, e_ovf3;

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_cnt = 0;
    hist1 = 0; hist2 = 0; hist3 = 0;
    e_valid = 0; e_freq8 = 0; e_ovf8 = 0; e_freq3 = 0; e_ovf3 = 0;
  endtask

  task automatic model_step();
    bit r;
    if (!clr_n) begin
      model_reset();
      return;
    end
    r = hist2 && !hist3;
    e_valid = 0;
    if (!m_active) begin
      m_active = en;
      m_pos = 0;
      m_cnt = 0;
    end else begin
      m_cnt += int'(r);
      if (m_pos == G - 1) begin
        e_valid = 1;
        e_freq8 = (m_cnt > 255) ? 255 : m_cnt;
        e_ovf8  = (m_cnt > 255) ? 1 : 0;
        e_freq3 = (m_cnt > 7) ? 7 : m_cnt;
        e_ovf3  = (m_cnt > 7) ? 1 : 0;
        m_cnt = 0;
        m_pos = 0;
        m_active = en;
      end else if (!en) begin
        m_active = 0;
        m_pos = 0;
        m_cnt = 0;
      end else begin
        m_pos++;
      end
    end
    hist3 = hist2;
    hist2 = hist1;
    hist1 = sig_in;
  endtask

  task automatic check_outputs();
    check("valid8", 32'(valid8), 32'(e_valid));
    check("freq8",  32'(freq8),  32'(e_freq8));
    check("ovf8",   32'(ovf8),   32'(e_ovf8));
    check("valid3", 32'(valid3), 32'(e_valid));
    check("freq3",  32'(freq3),  32'(e_freq3));
    check("ovf3",   32'(ovf3),   32'(e_ovf3));
  endtask

  // ---------------- stimulus ----------------
  localparam int M_LOW = 0, M_HIGH = 1, M_P4 = 2, M_TOG = 3, M_RND = 4, M_PULSE = 5;
  int mode = M_LOW;
  int t = 0;
  int pulse_t = -1;

  task automatic apply_sig();
    case (mode)
      M_LOW:   sig_in = 1'b0;
      M_HIGH:  sig_in = 1'b1;
      M_P4:    sig_in = ((t % 4) < 2);
      M_TOG:   sig_in = t[0];
      M_RND:   sig_in = 1'($urandom % 2);
      M_PULSE: sig_in = (t == pulse_t);
      default: sig_in = 1'b0;
    endcase
  endtask

  task automatic tick();
    apply_sig();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    t++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (valid8) return;
    end
    check("wait_valid_timeout", 32'(0), 32'(1));
  endtask

  int c;
  int hits;

  initial begin
    clr_n = 1'b0;
    en = 1'b0;
    sig_in = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with random inputs, then released with en=0.
    mode = M_RND;
    repeat (6) begin
      en = 1'($urandom % 2);
      tick();
    end
    check("rst_freq", 32'(freq8), 32'(0));
    clr_n = 1'b1;
    en = 1'b0;
    run(6);
    check("idle_valid", 32'(valid8), 32'(0));

    // Period-4 signal, continuous enable.
    mode = M_P4;
    en = 1'b1;
    run(20);
    wait_valid(c);
    repeat (3) begin
      wait_valid(c);
      check("p4_period", 32'(c), 32'(G));
      check("p4_freq", 32'(freq8), 32'(4));
      check("p4_ovf", 32'(ovf8), 32'(0));
    end

    // Constant input gives zero; a single pulse lands in exactly one window.
    mode = M_HIGH;
    run(40);
    check("high_freq", 32'(freq8), 32'(0));
    mode = M_LOW;
    run(40);
    pulse_t = t + 5;
    mode = M_PULSE;
    hits = 0;
    repeat (60) begin
      tick();
      if (valid8 && freq8 == 8'd1) hits++;
    end
    check("pulse_windows", 32'(hits), 32'(1));

    // Toggle every clk: 8 rises per window saturates the 3-bit counter.
    mode = M_TOG;
    run(32);
    wait_valid(c);
    check("tog_freq3", 32'(freq3), 32'(7));
    check("tog_ovf3", 32'(ovf3), 32'(1));
    check("tog_freq8", 32'(freq8), 32'(8));
    mode = M_P4;
    wait_valid(c);
    wait_valid(c);
    check("p4_after_sat_freq3", 32'(freq3), 32'(4));
    check("p4_after_sat_ovf3", 32'(ovf3), 32'(0));

    // Abort at gate cycle 10, then re-enable.
    wait_valid(c);
    run(10);
    en = 1'b0;
    hits = 0;
    repeat (20) begin
      tick();
      if (valid8) hits++;
    end
    check("abort_no_valid", 32'(hits), 32'(0));
    check("abort_freq_hold", 32'(freq8), 32'(4));
    en = 1'b1;
    wait_valid(c);
    check("reen_latency", 32'(c), 32'(G + 1));

    // Reset mid-window at gate cycle 8.
    wait_valid(c);
    run(8);
    clr_n = 1'b0;
    model_reset();
    #1;
    check("midrst_freq", 32'(freq8), 32'(0));
    check("midrst_valid", 32'(valid8), 32'(0));
    check("midrst_ovf3", 32'(ovf3), 32'(0));
    run(2);
    clr_n = 1'b1;
    en = 1'b1;
    wait_valid(c);
    check("post_rst_latency", 32'(c), 32'(G + 1));

    // Random traffic with occasional enable drops and resets.
    mode = M_RND;
    repeat (500) begin
      en = (($urandom % 20) != 0);
      clr_n = (($urandom % 80) != 0);
      tick();
    end
    clr_n = 1'b1;
    en = 1'b1;
    run(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_freq_meter
`default_nettype wire
